// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//                c_INIT_PC is the reset PC, which the core also uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int                c_XLEN    = 32;
    localparam logic [c_XLEN-1:0] c_INIT_PC = 32'h0000_0000;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch FIFO of fetch_entry_t.
//                Ports: push/push_data write an entry, pop retires the head,
//                flush empties the FIFO. head is the oldest entry, count is
//                the occupancy, and empty/full are status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int c_AW  = $clog2(DEPTH),
    localparam int c_CW  = c_AW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head,
    output logic [c_CW-1:0] count,
    output logic            empty,
    output logic            full
);

    // The pointers carry one extra wrap bit, so full and empty are
    // distinguishable without a separate occupancy register.
    logic [c_CW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_rd_ptr;
    fetch_entry_t    r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_CW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_CW'(1);
        end
    end

    // The storage array is not reset. The pointers alone define which entries
    // are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

    assign count = r_wr_ptr - r_rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == c_CW'(DEPTH));
    assign head  = r_mem[r_rd_ptr[c_AW-1:0]];

    a_no_push_full : assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !flush && full));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && !flush && empty));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. The block issues word reads through
//                a mem_req/mem_gnt interface and accepts in-order mem_rvalid
//                responses. It buffers {pc, instr} in a prefetch FIFO and
//                presents the head through instr_valid/instr_ready.
//                redirect/redirect_pc flush the FIFO, restart fetch, and
//                discard any responses that are still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] INIT_PC = c_INIT_PC,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int            c_CW        = $clog2(DEPTH) + 1;
    localparam logic [c_CW:0] c_DEPTH_EXT = (c_CW + 1)'(DEPTH);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic            r_active;

    logic [c_CW-1:0] w_count;
    logic [c_CW:0]   w_credit_sum;
    logic [c_CW-1:0] w_outstanding_next;
    logic            w_issue;
    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [31:0]     w_redirect_pc;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_unused;

    // Entries already buffered and requests still in flight share the FIFO
    // capacity. Because of this, a returning response always has a free slot.
    assign w_credit_sum = {1'b0, w_count} + {1'b0, r_outstanding};

    // r_active clears asynchronously with reset. This holds mem_req low while
    // reset is asserted, although the fetch state would otherwise allow a
    // request.
    assign mem_req  = r_active && !redirect && (w_credit_sum < c_DEPTH_EXT);
    assign mem_addr = r_fetch_pc;

    assign w_issue = mem_req && mem_gnt;
    // A response with nothing outstanding is a protocol violation, so it is
    // ignored here.
    assign w_rsp   = mem_rvalid && (r_outstanding != '0);
    assign w_drop  = w_rsp && (r_drop_cnt != '0);
    assign w_push  = w_rsp && !w_drop && !redirect;
    assign w_pop   = !w_empty && instr_ready && !redirect;

    assign w_outstanding_next = r_outstanding + c_CW'(w_issue) - c_CW'(w_rsp);
    assign w_redirect_pc      = {redirect_pc[31:2], 2'b00};

    assign w_push_entry.pc    = r_rsp_pc;
    assign w_push_entry.instr = mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= INIT_PC;
            r_rsp_pc      <= INIT_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_active      <= 1'b0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= w_outstanding_next;
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                // Every request still in flight after this cycle belongs to
                // the old stream. This count already includes any earlier
                // drop_cnt.
                r_drop_cnt <= w_outstanding_next;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)  r_rsp_pc   <= r_rsp_pc + 32'd4;
                if (w_drop)  r_drop_cnt <= r_drop_cnt - c_CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    // The outputs are masked while the FIFO is empty. As a result, they read
    // zero out of reset instead of showing stale storage.
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? 32'h0 : w_head.instr;
    assign instr_pc    = w_empty ? 32'h0 : w_head.pc;

    assign w_unused = ^{redirect_pc[1:0], w_full};

    a_addr_aligned : assert property (@(posedge clk) disable iff (!reset_n)
        mem_addr[1:0] == 2'b00);
    a_outstanding_cap : assert property (@(posedge clk) disable iff (!reset_n)
        r_outstanding <= c_DEPTH_CNT);
    a_rvalid_protocol : assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_rvalid && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed testbench for fetch_unit. A latency-configurable
//                memory model returns rdata = addr ^ 32'hA5A5_0000. The bench
//                logs grants and deliveries and compares them against
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    fetch_unit #(
        .INIT_PC (32'h0000_0000),
        .DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    logic [31:0] grant_addr[$];
    logic [31:0] grant_cyc[$];
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_instr[$];
    logic [31:0] deliv_cyc[$];
    int          cyc;
    int          lat;
    logic        gnt_en;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_before;
    int          g_before;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic clear_logs();
        grant_addr.delete();
        grant_cyc.delete();
        deliv_pc.delete();
        deliv_instr.delete();
        deliv_cyc.delete();
    endtask

    // One clock cycle. The caller sets redirect/instr_ready at posedge+1.
    // This task then drives the memory, samples the settled handshakes, and
    // advances to the next posedge+1.
    task automatic step();
        mem_gnt = gnt_en;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pending[0].addr ^ 32'hA5A5_0000;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        #1;
        if (mem_rvalid) void'(pending.pop_front());
        if (mem_req && mem_gnt) begin
            pending.push_back('{addr: mem_addr, due: cyc + lat});
            grant_addr.push_back(mem_addr);
            grant_cyc.push_back(32'(cyc));
        end
        if (instr_valid && instr_ready && !redirect) begin
            deliv_pc.push_back(instr_pc);
            deliv_instr.push_back(instr);
            deliv_cyc.push_back(32'(cyc));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        gnt_en      = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        pending.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gnt_en = 1'b0;
        lat    = 1;
        #1;
        check("rst_mem_req",     mem_req,     32'h0);
        check("rst_instr_valid", instr_valid, 32'h0);
        check("rst_instr",       instr,       32'h0);
        check("rst_instr_pc",    instr_pc,    32'h0);
        check("rst_mem_addr",    mem_addr,    32'h0);

        // 1: streaming with latency 1
        do_reset();
        lat = 1; gnt_en = 1'b1; instr_ready = 1'b1;
        run(12);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_addr%0d", i), qget(grant_addr, i), 32'(4 * i));
        check("t1_first_lat", qget(deliv_cyc, 0) - qget(grant_cyc, 0), 32'd2);
        check("t1_first_pc",  qget(deliv_pc, 0),    32'h0);
        check("t1_first_ins", qget(deliv_instr, 0), 32'hA5A5_0000);
        check("t1_rate_a",    qget(deliv_cyc, 4) - qget(deliv_cyc, 3), 32'd1);
        check("t1_rate_b",    qget(deliv_cyc, 5) - qget(deliv_cyc, 4), 32'd1);
        check("t1_pc5",       qget(deliv_pc, 5),    32'h14);
        check("t1_ins5",      qget(deliv_instr, 5), 32'hA5A5_0014);

        // 2: consumer stalled, FIFO fills up
        do_reset();
        lat = 1; gnt_en = 1'b1; instr_ready = 1'b0;
        run(10);
        check("t2_ngrant",   32'(grant_addr.size()), 32'd4);
        check("t2_last",     qget(grant_addr, 3), 32'hC);
        check("t2_req_full", mem_req,     32'h0);
        check("t2_valid",    instr_valid, 32'h1);
        check("t2_head_pc",  instr_pc,    32'h0);
        instr_ready = 1'b1;
        run(8);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_out%0d", i), qget(deliv_pc, i), 32'(4 * i));
        check("t2_next_req", qget(grant_addr, 4), 32'h10);

        // 3: redirect while two latency-3 requests are in flight
        do_reset();
        lat = 3; gnt_en = 1'b0; instr_ready = 1'b1;
        step();
        gnt_en = 1'b1;
        run(2);
        gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0; gnt_en = 1'b1;
        run(10);
        check("t3_ngrant_pre", qget(grant_addr, 1), 32'h4);
        check("t3_addr_redir", qget(grant_addr, 2), 32'h100);
        check("t3_first_pc",   qget(deliv_pc, 0),    32'h100);
        check("t3_first_ins",  qget(deliv_instr, 0), 32'hA5A5_0100);
        check("t3_second_pc",  qget(deliv_pc, 1),    32'h104);

        // 4: redirect together with a response and a pop, unaligned target
        do_reset();
        lat = 1; gnt_en = 1'b1; instr_ready = 1'b1;
        run(6);
        check("t4_pre_valid", instr_valid, 32'h1);
        n_before = deliv_pc.size();
        g_before = grant_addr.size();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        check("t4_flushed",   instr_valid, 32'h0);
        check("t4_no_pop",    32'(deliv_pc.size()), 32'(n_before));
        step();
        check("t4_no_push",   instr_valid, 32'h0);
        run(4);
        check("t4_restart",   qget(grant_addr, g_before), 32'h100);
        check("t4_first_pc",  qget(deliv_pc, n_before),    32'h100);
        check("t4_first_ins", qget(deliv_instr, n_before), 32'hA5A5_0100);

        // 5: asynchronous reset with 3 entries buffered and 1 in flight
        do_reset();
        lat = 2; gnt_en = 1'b1; instr_ready = 1'b0;
        run(6);
        check("t5_pre_valid", instr_valid, 32'h1);
        check("t5_pre_pc",    instr_pc,    32'h0);
        check("t5_pre_ins",   instr,       32'hA5A5_0000);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_arst_valid", instr_valid, 32'h0);
        check("t5_arst_req",   mem_req,     32'h0);
        check("t5_arst_ins",   instr,       32'h0);
        check("t5_arst_addr",  mem_addr,    32'h0);
        pending.delete();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        clear_logs();
        run(3);
        check("t5_first_addr", qget(grant_addr, 0), 32'h0);

        // 6: PC wrap at the top of the address space
        do_reset();
        lat = 1; gnt_en = 1'b1; instr_ready = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        run(5);
        check("t6_addr0", qget(grant_addr, 0),  32'hFFFF_FFFC);
        check("t6_addr1", qget(grant_addr, 1),  32'h0000_0000);
        check("t6_pc0",   qget(deliv_pc, 0),    32'hFFFF_FFFC);
        check("t6_ins0",  qget(deliv_instr, 0), 32'h5A5A_FFFC);
        check("t6_pc1",   qget(deliv_pc, 1),    32'h0000_0000);
        check("t6_ins1",  qget(deliv_instr, 1), 32'hA5A5_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute path. It keeps the fetch PC and issues word reads to a variable-latency instruction memory through a request/grant interface. Returned words are buffered with their PCs in a small prefetch FIFO and presented to the core through a valid/ready handshake. A redirect input flushes the buffer and restarts fetch at a new PC, and the block discards any memory responses that were already in flight.

Parameters:
InitPc, 32'h0, fetch PC after reset
Depth, 4, prefetch FIFO entries; power of two, >= 2; also caps in-flight requests

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
mem_req  output  1  read request valid
mem_addr  output  32  word-aligned read address, bits [1:0] always 0
mem_gnt  input  1  memory accepts request this cycle when mem_req=1
mem_rvalid  input  1  read data valid; in order; never in the same cycle as its grant
mem_rdata  input  32  read data
instr_valid  output  1  FIFO head valid
instr_ready  input  1  consumer accepts head
instr  output  32  head instruction word
instr_pc  output  32  head instruction PC
redirect  input  1  flush and restart fetch
redirect_pc  input  32  new fetch PC; bits [1:0] ignored

Behaviour:
- Reset (reset_n=0, asynchronous) drives the following values:
  - fetch_pc=InitPc, rsp_pc=InitPc.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - mem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Issue: mem_req = !redirect && (fifo_count + outstanding < Depth). mem_req is combinational from registered state and redirect.
- mem_addr = fetch_pc.
- On mem_req && mem_gnt: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Response: every mem_rvalid decrements outstanding. Responses are always accepted; there is no backpressure to memory.
- A response with drop_cnt>0 is discarded and drop_cnt decrements.
- Otherwise the entry {rsp_pc, mem_rdata} is pushed and rsp_pc += 4.
- The credit rule guarantees a push never finds the FIFO full.
- Output: instr_valid = FIFO non-empty. instr and instr_pc show the head entry.
- Pop when instr_valid && instr_ready.
- Push and pop in the same cycle are both honoured; the count is unchanged.
- Latency: a response in cycle N appears at the output in cycle N+1. There is no bypass.
- Redirect (priority over every same-cycle event):
  - FIFO cleared. A same-cycle pop is a no-op and a same-cycle response is not pushed.
  - fetch_pc <= rsp_pc <= {redirect_pc[31:2], 2'b00}.
  - drop_cnt <= outstanding_next, where outstanding_next = outstanding minus any same-cycle response. Existing drop_cnt is subsumed, because outstanding already counts the requests being dropped.
  - mem_req=0 in the redirect cycle, so no grant is counted.
  - Back-to-back redirects: the last one wins.
- After a redirect, fetch resumes when credits allow. Credits count dropped in-flight requests until their responses return.
- mem_rvalid with outstanding=0 is a protocol error: ignore it and flag it with an assertion.
- Simulation assertions:
  - mem_addr[1:0]==0.
  - outstanding <= Depth.
  - No push to a full FIFO.

Decomposition:
- Shared package fetch_pkg:
  - localparam XLEN=32.
  - typedef fetch_entry_t = packed struct {pc[31:0], instr[31:0]}.
  - Default InitPc constant, shared with the core.
- One sub-module: fetch_fifo.
  - Synchronous FIFO of fetch_entry_t, Depth entries, pointer width clog2(Depth)+1.
  - Ports: push, pop, flush, head, count, empty/full.
  - Uses the same asynchronous active-low reset.
- Top level holds fetch_pc, rsp_pc, outstanding, drop_cnt and the issue logic.

Test Plan:
1. Release reset with InitPc=0; memory grants every request and returns data one cycle later with rdata=addr^32'hA5A5_0000; instr_ready=1.
   -> mem_addr sequence is 0x0, 0x4, 0x8, ...
   -> First instr_valid is two cycles after the first grant, with instr_pc=0x0 and instr=0xA5A5_0000.
   -> Steady state delivers one instruction per cycle.
2. Same memory model with instr_ready=0.
   -> Exactly 4 grants (0x0 to 0xC), then mem_req stays 0 with the FIFO full.
   -> Raise instr_ready: outputs 0x0, 0x4, 0x8, 0xC in order, and the next request is to 0x10.
3. Memory latency 3 cycles; pulse redirect with redirect_pc=0x100 while 2 requests are in flight.
   -> Those 2 responses are dropped.
   -> The next mem_addr is 0x100, and the first instr_pc after the redirect is 0x100.
4. Redirect with redirect_pc=0x102 in the same cycle as a response and a pop.
   -> FIFO is empty the next cycle and the response is not delivered.
   -> Fetch restarts at 0x100.
5. Assert reset_n low asynchronously mid-stream with 3 FIFO entries and 1 request in flight; the memory model resets too.
   -> instr_valid=0 and mem_req=0 immediately, without waiting for a clock edge.
   -> After release, the first mem_addr equals InitPc.
6. Set fetch_pc to 0xFFFF_FFFC via redirect.
   -> Next two requests are 0xFFFF_FFFC then 0x0000_0000, and the delivered PCs wrap the same way.
